// File: rtl/bus_pkg.sv
// Shared bus definitions: address/data widths used by the bus, its slaves and
// the DMA master, plus the DMA controller state encoding.
package bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RD_CAP = 3'd2,
        ST_WR     = 3'd3,
        ST_DONE   = 3'd4
    } dma_state_t;

endpackage

// File: rtl/dma_ctr.sv
// Loadable word-address counter with increment enable; wraps modulo 2^WIDTH.
module dma_ctr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bus_dma_master.sv
// Block-copy bus master: moves len words from src_addr to dst_addr through the
// arbitrated bus, one read then one write per word, in ascending address order.
module bus_dma_master #(
    parameter int ADDR_W = bus_pkg::ADDR_W,
    parameter int DATA_W = bus_pkg::DATA_W,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_dout,
    input  logic              m_grant,
    input  logic [DATA_W-1:0] m_din
);

    import bus_pkg::*;

    dma_state_t        state;
    dma_state_t        state_nxt;
    logic [ADDR_W-1:0] src_cnt;
    logic [ADDR_W-1:0] dst_cnt;
    logic [LEN_W-1:0]  rem;
    logic [DATA_W-1:0] data_reg;
    logic              accept;
    logic              step;

    // accept: start seen in IDLE; step: a granted write retires one word
    assign accept = (state == ST_IDLE) && start;
    assign step   = (state == ST_WR) && m_grant;

    dma_ctr #(.WIDTH(ADDR_W)) u_src_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .load_val (src_addr),
        .inc      (step),
        .cnt      (src_cnt)
    );

    dma_ctr #(.WIDTH(ADDR_W)) u_dst_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .load_val (dst_addr),
        .inc      (step),
        .cnt      (dst_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            rem      <= '0;
            data_reg <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rem <= len;
            end else if (step) begin
                rem <= rem - 1'b1;
            end
            // read data lands one cycle after the granted read, i.e. in RD_CAP
            if (state == ST_RD_CAP) begin
                data_reg <= m_din;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        m_req     = 1'b0;
        m_wr      = 1'b0;
        m_address = '0;
        m_dout    = '0;
        done      = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                m_req     = 1'b1;
                m_address = src_cnt;
                if (m_grant) begin
                    state_nxt = ST_RD_CAP;
                end
            end
            ST_RD_CAP: begin
                // keep requesting so the grant is not lost before the write
                m_req     = 1'b1;
                m_address = src_cnt;
                state_nxt = ST_WR;
            end
            ST_WR: begin
                m_req     = 1'b1;
                m_wr      = 1'b1;
                m_address = dst_cnt;
                m_dout    = data_reg;
                if (m_grant) begin
                    state_nxt = (rem == LEN_W'(1)) ? ST_DONE : ST_RD;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_dma_master.sv
// Scoreboard bench for bus_dma_master: a flat 256-word memory stands in for
// the bus slaves; expected bus transactions and done cycles are queued at start.
module tb_bus_dma_master;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } txn_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic        m_req;
    logic        m_wr;
    logic [7:0]  m_address;
    logic [31:0] m_dout;
    logic        m_grant;
    logic [31:0] m_din = '0;

    logic [31:0] mem [256];
    logic        mem_ready = 1'b0;
    logic [31:0] xd [8];
    logic [15:0] lfsr = 16'hACE1;
    bit          grant_rand = 1'b0;

    txn_t sb[$];
    int   dq[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   n_rd = 0;
    int   n_wr = 0;
    int   n_done = 0;
    int   done_base = 0;
    int   cyc = 0;

    bus_dma_master #(.ADDR_W(8), .DATA_W(32), .LEN_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_address (m_address),
        .m_dout    (m_dout),
        .m_grant   (m_grant),
        .m_din     (m_din)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory image P(a) = 0xA5A5_0000 | a, then serve granted reads/writes
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
            mem_ready <= 1'b1;
        end else if (m_req && m_grant) begin
            if (m_wr) mem[m_address] <= m_dout;
            else      m_din <= mem[m_address];
        end
    end

    initial begin
        m_grant = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (grant_rand) begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                m_grant = lfsr[0];
            end else begin
                m_grant = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every new granted transaction
    logic p_req = 0, p_grant = 0, p_wr = 0, p_gr_rd = 0, pp_gr_rd = 0, cur_gr_rd;
    logic [7:0] p_addr = '0;
    txn_t e;
    int   x;
    always @(negedge clk) begin
        if (!reset_n) begin
            p_req = 0; p_grant = 0; p_wr = 0; p_gr_rd = 0; pp_gr_rd = 0; p_addr = '0;
        end else begin
            cur_gr_rd = m_req && m_grant && !m_wr;
            if (m_req && m_grant && !(cur_gr_rd && p_gr_rd)) begin
                if (m_wr) n_wr++; else n_rd++;
                if (sb.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_txn: wr=%0b addr=%h dout=%h, none expected", m_wr, m_address, m_dout);
                end else begin
                    e = sb.pop_front();
                    chk("bus_txn", 64'({m_wr, m_address, m_dout}),
                        64'({e.wr, e.addr, (e.wr ? e.data : 32'h0)}));
                end
            end
            if (p_req && !p_grant && !pp_gr_rd)
                chk("stall_hold", 64'({m_req, m_wr, m_address}), 64'({1'b1, p_wr, p_addr}));
            if (done) begin
                n_done++;
                if (dq.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL unexpected_done: cycle %0d, none expected", cyc);
                end else begin
                    x = dq.pop_front();
                    if (x >= 0) chk("done_cycle", 64'(cyc), 64'(x));
                end
            end
            pp_gr_rd = p_gr_rd;
            p_gr_rd  = cur_gr_rd;
            p_req    = m_req;
            p_grant  = m_grant;
            p_wr     = m_wr;
            p_addr   = m_address;
        end
    end

    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n, input bit timed);
        @(negedge clk);
        for (int i = 0; i < int'(n); i++) begin
            sb.push_back('{1'b0, s + 8'(i), 32'h0});
            sb.push_back('{1'b1, d + 8'(i), xd[i]});
        end
        done_base = n_done;
        dq.push_back(timed ? cyc + 3 * int'(n) + 1 : -1);
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done == done_base; i++) @(negedge clk);
        chk("done_seen", 64'(n_done - done_base), 64'd1);
        @(negedge clk);
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("sb_drained", 64'(sb.size() + dq.size()), 64'd0);
    endtask

    initial begin
        int r0, w0;
        reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({m_req, m_wr, m_address, m_dout, busy, done}), 64'd0);
        reset_n = 1'b1;

        // Basic copy 0x00..0x03 -> 0x20..0x23
        for (int i = 0; i < 4; i++) xd[i] = 32'hA5A5_0000 + 32'(i);
        run_copy(8'h00, 8'h20, 8'd4, 1'b1);
        wait_done(60);
        chk("basic_dst0", 64'(mem[8'h20]), 64'h0000_0000_A5A5_0000);
        chk("basic_dst1", 64'(mem[8'h21]), 64'h0000_0000_A5A5_0001);
        chk("basic_dst2", 64'(mem[8'h22]), 64'h0000_0000_A5A5_0002);
        chk("basic_dst3", 64'(mem[8'h23]), 64'h0000_0000_A5A5_0003);

        // Empty copy
        run_copy(8'h10, 8'h30, 8'd0, 1'b1);
        chk("len0_no_req", 64'(m_req), 64'd0);
        wait_done(10);
        chk("len0_no_req_after", 64'(m_req), 64'd0);

        // Contention: 0x40..0x43 -> 0x60..0x63 with random grant
        for (int i = 0; i < 4; i++) xd[i] = 32'hA5A5_0040 + 32'(i);
        r0 = n_rd; w0 = n_wr;
        grant_rand = 1'b1;
        run_copy(8'h40, 8'h60, 8'd4, 1'b0);
        wait_done(400);
        grant_rand = 1'b0;
        chk("cont_reads", 64'(n_rd - r0), 64'd4);
        chk("cont_writes", 64'(n_wr - w0), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("cont_dst", 64'(mem[8'h60 + i]), 64'(32'hA5A5_0040 + 32'(i)));
        @(negedge clk);

        // Wrap with overlapping dst: every write carries P(0xFE)
        for (int i = 0; i < 3; i++) xd[i] = 32'hA5A5_00FE;
        run_copy(8'hFE, 8'hFF, 8'd3, 1'b1);
        wait_done(60);
        chk("wrap_ff", 64'(mem[8'hFF]), 64'h0000_0000_A5A5_00FE);
        chk("wrap_00", 64'(mem[8'h00]), 64'h0000_0000_A5A5_00FE);
        chk("wrap_01", 64'(mem[8'h01]), 64'h0000_0000_A5A5_00FE);

        // start while busy is ignored
        for (int i = 0; i < 3; i++) xd[i] = 32'hA5A5_0050 + 32'(i);
        run_copy(8'h50, 8'h70, 8'd3, 1'b1);
        @(negedge clk);
        src_addr = 8'h10; dst_addr = 8'h30; len = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(60);
        chk("busy_dst0", 64'(mem[8'h70]), 64'h0000_0000_A5A5_0050);
        chk("busy_dst2", 64'(mem[8'h72]), 64'h0000_0000_A5A5_0052);
        chk("busy_no_stray", 64'(mem[8'h30]), 64'h0000_0000_A5A5_0030);

        // Mid-copy reset during the write of the second word
        for (int i = 0; i < 4; i++) xd[i] = 32'hA5A5_0080 + 32'(i);
        run_copy(8'h80, 8'hA0, 8'd4, 1'b1);
        repeat (5) @(posedge clk);
        #2;
        chk("pre_reset_wr", 64'({m_wr, m_address}), 64'({1'b1, 8'hA1}));
        reset_n = 1'b0;
        #1;
        chk("async_reset_out", 64'({m_req, m_wr, m_address, m_dout, busy, done}), 64'd0);
        sb.delete();
        dq.delete();
        @(negedge clk);
        chk("reset_idle", 64'({busy, m_req}), 64'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 2; i++) xd[i] = 32'hA5A5_0090 + 32'(i);
        run_copy(8'h90, 8'hB0, 8'd2, 1'b1);
        wait_done(60);
        chk("rst_first_word", 64'(mem[8'hA0]), 64'h0000_0000_A5A5_0080);
        chk("rst_aborted_word", 64'(mem[8'hA1]), 64'h0000_0000_A5A5_00A1);
        chk("rst_new_dst0", 64'(mem[8'hB0]), 64'h0000_0000_A5A5_0090);
        chk("rst_new_dst1", 64'(mem[8'hB1]), 64'h0000_0000_A5A5_0091);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected to finish");
        $fatal(1);
    end

endmodule
